// File: rtl/quotient_converter.sv
// quotient_converter: on-the-fly radix-2 SRT quotient converter (Q/QM) with final remainder-sign correction
//   clk, rst (async, active-high)
//   start              clear Q/QM/digitCount and begin a conversion (also restarts a running one)
//   digitValid         SignSel/Non0 carry a digit {-1,0,+1} this cycle
//   SignSel, Non0      digit sign (1 = negative) and magnitude (0 = zero digit)
//   remNeg             final remainder negative, sampled in CORRECT
//   busy               high in CONVERT and CORRECT
//   done               one-cycle pulse, quotient valid
//   quotient           converted quotient, held until the next start or rst
//   digitCount         digits accepted so far
//   protocolErr        only with QCONV_PROTOCOL_ERR_EN: sticky flag for digitValid in IDLE/DONE
module quotient_converter #(
  parameter int parallelism = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               digitValid,
  input  logic                               SignSel,
  input  logic                               Non0,
  input  logic                               remNeg,
  output logic                               busy,
  output logic                               done,
  output logic [parallelism-1:0]             quotient,
  output logic [$clog2(parallelism+1)-1:0]   digitCount
`ifdef QCONV_PROTOCOL_ERR_EN
  , output logic                             protocolErr
`endif
);
  localparam int CW = $clog2(parallelism+1);
  typedef enum logic [1:0] {IDLE, CONVERT, CORRECT, DONE} state_t;
  state_t state;
  logic [parallelism-1:0] q, qm, q_nxt, qm_nxt;
  logic pos, neg, last, stray;
  always_comb begin
    pos = Non0 & ~SignSel;
    neg = Non0 & SignSel;
    // -1 borrows from QM; 0 and +1 extend Q with the digit value
    q_nxt = neg ? {qm[parallelism-2:0], 1'b1} : {q[parallelism-2:0], Non0};
    // +1 makes QM = old Q shifted; 0 and -1 extend QM with (digit-1) mod 2
    qm_nxt = pos ? {q[parallelism-2:0], 1'b0} : {qm[parallelism-2:0], ~Non0};
    last = digitCount == CW'(parallelism - 1);
    stray = digitValid && (state == IDLE || state == DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      qm         <= '1;
      quotient   <= '0;
      digitCount <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      state      <= CONVERT;
      q          <= '0;
      qm         <= '1;
      digitCount <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        CONVERT: if (digitValid) begin
          q          <= q_nxt;
          qm         <= qm_nxt;
          digitCount <= digitCount + CW'(1);
          state      <= last ? CORRECT : CONVERT;
        end
        CORRECT: begin
          quotient <= remNeg ? qm : q;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef QCONV_PROTOCOL_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) protocolErr <= 1'b0;
    else protocolErr <= start ? 1'b0 : (protocolErr | stray);
  end
`else
  logic unused_stray;
  assign unused_stray = stray;
`endif
endmodule
